// File: rtl/vec_lane_multiplier_pkg.sv
// Shared definitions for the packed-lane multiplier: element-width encoding,
// lane counts and the operand extension helpers used by the SEW loaders.
package vec_lane_multiplier_pkg;

    // Element width selector. The encoding 2'b11 is reserved and flagged
    // as illegal by the datapath.
    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    // Width of one packed operand word.
    localparam int WORD_W = 32;

    // Number of independent lanes per word for each element width.
    localparam int LANES_SEW8  = 4;
    localparam int LANES_SEW16 = 2;
    localparam int LANES_SEW32 = 1;

    // Widen an 8-bit element to the 16-bit product width. The upper byte
    // is a sign fill when is_signed is set, zero fill otherwise.
    function automatic logic [15:0] ext8_to16(input logic [7:0] v, input logic is_signed);
        ext8_to16 = {{8{is_signed & v[7]}}, v};
    endfunction

    // Widen a 16-bit element to the 32-bit product width.
    function automatic logic [31:0] ext16_to32(input logic [15:0] v, input logic is_signed);
        ext16_to32 = {{16{is_signed & v[15]}}, v};
    endfunction

    // Widen a 32-bit element to the 64-bit product width.
    function automatic logic [63:0] ext32_to64(input logic [31:0] v, input logic is_signed);
        ext32_to64 = {{32{is_signed & v[31]}}, v};
    endfunction

endpackage

// File: rtl/vec_lane_multiplier_lane_mul32.sv
// Combinational SEW-partitioned multiplier for one 32-bit word.
// Each lane is widened to twice its element width (sign or zero fill) and
// multiplied at that width, so the low 2*SEW bits of the unsigned product
// equal the exact signed/unsigned lane product and no carry ever crosses
// a lane boundary. The requested half of every lane product is packed back
// into a 32-bit word; the reserved width code yields zero and a flag.
module lane_mul32
    import vec_lane_multiplier_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  sew,
    input  logic        op_signed,
    input  logic        high_sel,
    output logic [31:0] result,
    output logic        illegal
);

    logic [15:0] prod8_s  [LANES_SEW8];
    logic [31:0] prod16_s [LANES_SEW16];
    logic [63:0] prod32_s;

    // Full-width 8x8 lane products for the four byte lanes.
    always_comb begin
        for (int i = 0; i < LANES_SEW8; i++) begin
            prod8_s[i] = ext8_to16(a[i*8 +: 8], op_signed) * ext8_to16(b[i*8 +: 8], op_signed);
        end
    end

    // Full-width 16x16 lane products for the two halfword lanes.
    always_comb begin
        for (int j = 0; j < LANES_SEW16; j++) begin
            prod16_s[j] = ext16_to32(a[j*16 +: 16], op_signed) * ext16_to32(b[j*16 +: 16], op_signed);
        end
    end

    // Full-width 32x32 product for the single word lane.
    always_comb begin
        prod32_s = ext32_to64(a, op_signed) * ext32_to64(b, op_signed);
    end

    // Pick the low or high half of each lane product and pack the lanes.
    always_comb begin
        result  = 32'h0000_0000;
        illegal = 1'b0;
        case (sew)
            SEW8: begin
                for (int k = 0; k < LANES_SEW8; k++) begin
                    if (high_sel) begin
                        result[k*8 +: 8] = prod8_s[k][15:8];
                    end else begin
                        result[k*8 +: 8] = prod8_s[k][7:0];
                    end
                end
            end
            SEW16: begin
                for (int m = 0; m < LANES_SEW16; m++) begin
                    if (high_sel) begin
                        result[m*16 +: 16] = prod16_s[m][31:16];
                    end else begin
                        result[m*16 +: 16] = prod16_s[m][15:0];
                    end
                end
            end
            SEW32: begin
                if (high_sel) begin
                    result = prod32_s[63:32];
                end else begin
                    result = prod32_s[31:0];
                end
            end
            default: begin
                result  = 32'h0000_0000;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vec_lane_multiplier.sv
// Two-stage packed-lane multiplier with valid/ready handshakes on both
// sides. Stage 1 registers the operands and the per-beat control, and the
// lane multiplier works from those registers; stage 2 registers the
// selected packed result that drives the outputs. Each stage refills in the
// same cycle it drains, so one beat per cycle flows while out_ready is high.
// Only REG_WIDTH = 32 is supported.
module vec_lane_multiplier
    import vec_lane_multiplier_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           sew,
    input  logic                 op_signed,
    input  logic                 high_sel,
    input  logic [REG_WIDTH-1:0] data_a,
    input  logic [REG_WIDTH-1:0] data_b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] result,
    output logic                 illegal_sew
);

    // Stage 1: captured operands and the control that travels with them.
    logic                 s1_valid_r;
    logic [REG_WIDTH-1:0] s1_a_r;
    logic [REG_WIDTH-1:0] s1_b_r;
    logic [1:0]           s1_sew_r;
    logic                 s1_signed_r;
    logic                 s1_high_r;

    // Stage 2: selected packed result presented to the consumer.
    logic                 s2_valid_r;
    logic [REG_WIDTH-1:0] s2_result_r;
    logic                 s2_illegal_r;

    // Handshake terms.
    logic                 s2_open_s;
    logic                 s1_adv_s;
    logic                 in_ready_s;
    logic                 in_fire_s;

    // Lane multiplier output.
    logic [WORD_W-1:0]    lane_result_s;
    logic                 lane_illegal_s;

    // Flow control: stage 2 can take a beat when it is empty or being read
    // out, and stage 1 can take a new beat when it is empty or moving on.
    // in_valid does not feed in_ready; reset holds in_ready low.
    always_comb begin
        s2_open_s  = !s2_valid_r || out_ready;
        s1_adv_s   = s1_valid_r && s2_open_s;
        in_ready_s = rst_n && (!s1_valid_r || s1_adv_s);
        in_fire_s  = in_valid && in_ready_s;
    end

    lane_mul32 u_lane_mul32 (
        .a         (s1_a_r),
        .b         (s1_b_r),
        .sew       (s1_sew_r),
        .op_signed (s1_signed_r),
        .high_sel  (s1_high_r),
        .result    (lane_result_s),
        .illegal   (lane_illegal_s)
    );

    // Stage 1 register: accept a new beat whenever the stage is free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_a_r      <= {REG_WIDTH{1'b0}};
            s1_b_r      <= {REG_WIDTH{1'b0}};
            s1_sew_r    <= 2'b00;
            s1_signed_r <= 1'b0;
            s1_high_r   <= 1'b0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= in_valid;
            end else begin
                s1_valid_r <= s1_valid_r;
            end
            if (in_fire_s) begin
                s1_a_r      <= data_a;
                s1_b_r      <= data_b;
                s1_sew_r    <= sew;
                s1_signed_r <= op_signed;
                s1_high_r   <= high_sel;
            end else begin
                s1_a_r      <= s1_a_r;
                s1_b_r      <= s1_b_r;
                s1_sew_r    <= s1_sew_r;
                s1_signed_r <= s1_signed_r;
                s1_high_r   <= s1_high_r;
            end
        end
    end

    // Stage 2 register: load the lane result when stage 2 is open; hold
    // result and flag stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r   <= 1'b0;
            s2_result_r  <= {REG_WIDTH{1'b0}};
            s2_illegal_r <= 1'b0;
        end else if (s2_open_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_result_r  <= lane_result_s;
                s2_illegal_r <= lane_illegal_s;
            end else begin
                s2_result_r  <= s2_result_r;
                s2_illegal_r <= s2_illegal_r;
            end
        end else begin
            s2_valid_r   <= s2_valid_r;
            s2_result_r  <= s2_result_r;
            s2_illegal_r <= s2_illegal_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = s2_valid_r;
    assign result      = s2_result_r;
    assign illegal_sew = s2_illegal_r;

endmodule

// File: tb/tb_vec_lane_multiplier.sv
// Directed bench for vec_lane_multiplier: hand-computed vectors, single-beat
// latency checks, streamed beats under back-pressure, and mid-stall reset.
module tb_vec_lane_multiplier;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sew;
    logic        op_signed;
    logic        high_sel;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal_sew;

    int total;
    int bad;

    typedef struct {
        logic [1:0]  sew;
        logic        sgn;
        logic        hi;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } beat_t;

    beat_t tbl [10];
    int    seq [$];

    vec_lane_multiplier #(.REG_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sew         (sew),
        .op_signed   (op_signed),
        .high_sel    (high_sel),
        .data_a      (data_a),
        .data_b      (data_b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .illegal_sew (illegal_sew)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_beat(input int k);
        sew       = tbl[k].sew;
        op_signed = tbl[k].sgn;
        high_sel  = tbl[k].hi;
        data_a    = tbl[k].a;
        data_b    = tbl[k].b;
        in_valid  = 1'b1;
    endtask

    // One beat into an empty pipeline: result appears exactly two edges later.
    task automatic run_one(input int k, input string tag);
        drive_beat(k);
        out_ready = 1'b1;
        #1;
        check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_val({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_val({tag, "_res"}, result, tbl[k].res);
        check_val({tag, "_ill"}, 32'(illegal_sew), 32'(tbl[k].ill));
        @(posedge clk); #1;
        check_val({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    // Stream the beats listed in seq; pat_mode 1 cycles out_ready 1,0,0,1.
    task automatic run_stream(input int pat_mode);
        int         n;
        int         idx;
        int         done;
        int         occ;
        int         cyc;
        logic [3:0] pat;
        logic       inf;
        logic       of;
        n    = seq.size();
        idx  = 0;
        done = 0;
        occ  = 0;
        cyc  = 0;
        pat  = 4'b1001;
        while (done < n && cyc < 400) begin
            if (idx < n) drive_beat(seq[idx]);
            else in_valid = 1'b0;
            out_ready = (pat_mode == 1) ? pat[3 - (cyc % 4)] : 1'b1;
            #1;
            check_val("stream_rdy", 32'(in_ready), (occ < 2 || out_ready) ? 32'd1 : 32'd0);
            if (out_valid) begin
                if (done < n) begin
                    check_val("stream_res", result, tbl[seq[done]].res);
                    check_val("stream_ill", 32'(illegal_sew), 32'(tbl[seq[done]].ill));
                end else begin
                    check_val("stream_spurious", 32'(out_valid), 32'd0);
                end
            end
            inf = in_valid && in_ready;
            of  = out_valid && out_ready;
            @(posedge clk); #1;
            if (inf) begin idx++; occ++; end
            if (of) begin done++; occ--; end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("stream_count", 32'(done), 32'(n));
        check_val("stream_empty", 32'(out_valid), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        tbl[0] = '{2'b00, 1'b0, 1'b0, 32'h0403_0201, 32'h0202_0202, 32'h0806_0402, 1'b0};
        tbl[1] = '{2'b01, 1'b1, 1'b1, 32'hFFFF_8000, 32'h0002_8000, 32'hFFFF_4000, 1'b0};
        tbl[2] = '{2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        tbl[3] = '{2'b10, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[4] = '{2'b00, 1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0002, 32'h0000_00FF, 1'b0};
        tbl[5] = '{2'b00, 1'b0, 1'b1, 32'h0000_00FF, 32'h0000_0002, 32'h0000_0001, 1'b0};
        tbl[6] = '{2'b01, 1'b0, 1'b0, 32'h0003_0002, 32'h0004_0005, 32'h000C_000A, 1'b0};
        tbl[7] = '{2'b11, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1};
        tbl[8] = '{2'b10, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 1'b0};
        tbl[9] = '{2'b00, 1'b1, 1'b0, 32'h807F_02FE, 32'h02FF_0303, 32'h0081_06FA, 1'b0};

        rst_n     = 1'b0;
        sew       = 2'b00;
        op_signed = 1'b0;
        high_sel  = 1'b0;
        data_a    = 32'h0;
        data_b    = 32'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        @(posedge clk); #1;
        check_val("rst_rdy", 32'(in_ready), 32'd0);
        check_val("rst_vld", 32'(out_valid), 32'd0);
        check_val("rst_res", result, 32'h0);
        check_val("rst_ill", 32'(illegal_sew), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_val("rel_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Single beats covering each width, signedness and half.
        run_one(0, "u8_lo");
        run_one(1, "s16_hi");
        run_one(2, "u32_hi");
        run_one(3, "s32_hi");
        run_one(4, "s8_hi");
        run_one(5, "u8_hi");
        run_one(8, "s32_lo");
        run_one(9, "s8_lo");
        run_one(6, "u16_lo");
        run_one(7, "illegal");

        // Eight back-to-back beats with out_ready cycling 1,0,0,1.
        seq.delete();
        for (int i = 0; i < 8; i++) seq.push_back(i);
        run_stream(1);
        @(posedge clk); #1;

        // Illegal beat sandwiched between two legal beats, no stall.
        seq.delete();
        seq.push_back(2);
        seq.push_back(7);
        seq.push_back(0);
        run_stream(0);
        @(posedge clk); #1;

        // Reset with two beats in flight and the consumer stalled.
        out_ready = 1'b0;
        drive_beat(0);
        @(posedge clk); #1;
        drive_beat(1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("full_vld", 32'(out_valid), 32'd1);
        check_val("full_rdy", 32'(in_ready), 32'd0);
        check_val("full_res", result, tbl[0].res);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check_val("mid_rst_vld", 32'(out_valid), 32'd0);
        check_val("mid_rst_res", result, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_vld", 32'(out_valid), 32'd0);
        run_one(5, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
